// File: rtl/systolic_sequencer_pkg.sv
// Shared types and defaults for the systolic array sequencer.
package systolic_sequencer_pkg;

    localparam int N_DEFAULT = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/systolic_sequencer_skew_line.sv
// Bank of N one-bit delay lines sharing an enable. Column j is delayed by
// j stages (REVERSE=0, input skew) or by N-1-j stages (REVERSE=1, output
// deskew). A zero-depth column is a straight wire.
module skew_line
    import systolic_sequencer_pkg::*;
#(
    parameter int N       = N_DEFAULT,
    parameter bit REVERSE = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout
);

    for (genvar j = 0; j < N; j++) begin : g_col
        localparam int D = REVERSE ? (N - 1 - j) : j;
        if (D == 0) begin : g_wire
            assign dout[j] = din[j];
        end else begin : g_reg
            logic [D-1:0] sr;
            // Shift one stage per enabled cycle; oldest bit leaves at sr[D-1].
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sr <= '0;
                end else if (en) begin
                    sr[0] <= din[j];
                    for (int k = 1; k < D; k++) begin
                        sr[k] <= sr[k-1];
                    end
                end
            end
            assign dout[j] = sr[D-1];
        end
    end

endmodule

// File: rtl/systolic_sequencer.sv
// Sequencer for an external N-deep 1-bit systolic array: skews input rows
// into the array, deskews its outputs, and tracks valid vectors with a
// token pipeline so exactly N vectors leave per job, in order.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; array frozen
// S_FEED  | accepting N input rows, one array step per accepted row
// S_FLUSH | stepping zeros in for 2N-1 steps until all N outputs are taken
// S_DONE  | one-cycle completion pulse, then back to S_IDLE
module systolic_sequencer
    import systolic_sequencer_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         busy,
    output logic         done,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         arr_step,
    output logic [N-1:0] arr_din,
    input  logic [N-1:0] arr_dout
);

    // Counter width covers the longest count, the 2N-1 flush steps.
    localparam int CW = $clog2(2 * N);
    // Total pipeline depth from acceptance to out_data capture.
    localparam int TW = 2 * N - 1;
    localparam logic [CW-1:0] LAST_BEAT   = CW'(N - 1);
    localparam logic [CW-1:0] FLUSH_STEPS = CW'(2 * N - 1);
    localparam logic [CW-1:0] OUT_TOTAL   = CW'(N);

    state_t        state, state_nxt;
    logic          stall, handshake, accept, flush_step, step;
    logic [CW-1:0] beat_cnt, flush_cnt, out_cnt;
    logic [TW-1:0] tok;
    logic [N-1:0]  col_in, deskew_out;

    assign stall     = out_valid & ~out_ready;
    assign handshake = out_valid & out_ready;
    assign step      = accept | flush_step;
    assign arr_step  = step;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode; flush stops stepping once its count is reached.
    always_comb begin
        state_nxt  = state;
        busy       = 1'b1;
        done       = 1'b0;
        in_ready   = 1'b0;
        accept     = 1'b0;
        flush_step = 1'b0;
        col_in     = '0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = S_FEED;
                end
            end
            S_FEED: begin
                in_ready = ~stall;
                accept   = in_valid & ~stall;
                col_in   = in_data;
                if (accept && (beat_cnt == LAST_BEAT)) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                flush_step = ~stall & (flush_cnt != FLUSH_STEPS);
                if ((flush_cnt == FLUSH_STEPS) && (out_cnt == OUT_TOTAL)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Beat, flush and output counters, cleared when a job starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            flush_cnt <= '0;
            out_cnt   <= '0;
        end else if ((state == S_IDLE) && start) begin
            beat_cnt  <= '0;
            flush_cnt <= '0;
            out_cnt   <= '0;
        end else begin
            if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (flush_step) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
            if (handshake) begin
                out_cnt <= out_cnt + 1'b1;
            end
        end
    end

    // Token pipeline and output register; a capture takes priority over clearing out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (step) begin
                tok <= {tok[TW-2:0], accept};
            end
            if (step && tok[TW-1]) begin
                out_valid <= 1'b1;
                out_data  <= deskew_out;
            end else if (handshake) begin
                out_valid <= 1'b0;
            end
        end
    end

    skew_line #(.N(N), .REVERSE(1'b0)) u_skew (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (step),
        .din   (col_in),
        .dout  (arr_din)
    );

    skew_line #(.N(N), .REVERSE(1'b1)) u_deskew (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (step),
        .din   (arr_dout),
        .dout  (deskew_out)
    );

endmodule

// File: tb/tb_systolic_sequencer.sv
// Bench for systolic_sequencer with a behavioural N-deep pass-through array.
module tb_systolic_sequencer;
    import systolic_sequencer_pkg::*;

    localparam int N             = 8;
    localparam int STEPS_PER_JOB = 3 * N - 1;
    localparam int LAT           = 2 * N - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [N-1:0] in_data = '0;
    logic         busy, done, in_ready, out_valid, arr_step;
    logic [N-1:0] out_data, arr_din, arr_dout;

    typedef struct {
        logic [N-1:0] din;
        logic [N-1:0] exp;
    } vec_t;
    vec_t tbl [2*N];

    int checks = 0;
    int failures = 0;
    logic [N-1:0] exp_q [$];
    int n_out = 0;
    int n_step = 0;
    int n_done = 0;
    int cyc = 0;
    int first_acc = -1;
    int first_val = -1;

    logic [N-1:0] arr_row [N];

    systolic_sequencer #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .arr_step  (arr_step),
        .arr_din   (arr_din),
        .arr_dout  (arr_dout)
    );

    always #5 clk = ~clk;

    // External array model: N registered rows advancing on arr_step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) arr_row[k] <= '0;
        end else if (arr_step) begin
            arr_row[0] <= arr_din;
            for (int k = 1; k < N; k++) arr_row[k] <= arr_row[k-1];
        end
    end
    assign arr_dout = arr_row[N-1];

    // Edge counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor on the falling edge: step/done counts, feed stepping rule, output scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (arr_step) n_step++;
            if (done) n_done++;
            if (in_ready) chk("feed_step", {31'd0, arr_step}, {31'd0, in_valid});
            if (in_valid && in_ready && first_acc < 0) first_acc = cyc + 1;
            if (out_valid && first_val < 0) first_val = cyc;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_output: got %0h expected none", out_data);
                end else begin
                    chk("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
                end
                n_out++;
            end
        end
    end

    task automatic do_feed(input int base, input bit gap);
        for (int i = 0; i < N; i++) begin
            bit acc;
            int bound;
            if (gap && i > 0) begin
                in_valid = 1'b0;
                in_data  = '1;
                tick();
            end
            in_valid = 1'b1;
            in_data  = tbl[base+i].din;
            acc   = 1'b0;
            bound = 0;
            while (!acc && bound < 200) begin
                @(negedge clk);
                acc = in_ready;
                if (acc) exp_q.push_back(tbl[base+i].exp);
                tick();
                bound++;
            end
            if (!acc) begin
                checks++;
                failures++;
                $display("FAIL feed_timeout: beat %0d got no in_ready expected acceptance", i);
            end
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic do_drain(input int stall_after);
        int bound;
        out_ready = 1'b1;
        if (stall_after >= 0) begin
            bound = 0;
            while (n_out < stall_after && bound < 500) begin
                tick();
                bound++;
            end
            out_ready = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_data", {24'd0, out_data}, {24'd0, (exp_q.size() > 0) ? exp_q[0] : 8'h00});
                chk("stall_step", {31'd0, arr_step}, 32'd0);
                tick();
            end
            out_ready = 1'b1;
        end
    endtask

    task automatic run_job(input int base, input bit gap, input int stall_after, input bit spam,
                           input bit chk_lat);
        int bound;
        n_out = 0;
        n_step = 0;
        n_done = 0;
        first_acc = -1;
        first_val = -1;
        start = 1'b1;
        tick();
        start = spam;
        fork
            do_feed(base, gap);
            do_drain(stall_after);
            begin
                if (spam) begin
                    bound = 0;
                    while (n_out < 6 && bound < 500) begin
                        tick();
                        bound++;
                    end
                    start = 1'b0;
                end
            end
        join
        bound = 0;
        while (n_done == 0 && bound < 1000) begin
            tick();
            bound++;
        end
        chk("done_seen", n_done, 32'd1);
        chk("out_count", n_out, N);
        chk("step_count", n_step, STEPS_PER_JOB);
        chk("queue_empty", exp_q.size(), 32'd0);
        chk("busy_after", {31'd0, busy}, 32'd0);
        if (chk_lat) chk("latency", first_val - first_acc, LAT);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_arr_step", {31'd0, arr_step}, 32'd0);
        chk("rst_arr_din", {24'd0, arr_din}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            tbl[i].din = 8'(1) << i;
            tbl[i].exp = 8'(1) << i;
        end
        for (int i = N; i < 2 * N; i++) begin
            tbl[i].din = 8'(i * 37 + 5) ^ 8'h5A;
            tbl[i].exp = 8'(i * 37 + 5) ^ 8'h5A;
        end

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst_n = 1'b1;
        tick();

        // Walking ones, no stalls, with latency measurement.
        run_job(0, 1'b0, -1, 1'b0, 1'b1);
        // Output stalled for 20 cycles after three vectors.
        run_job(N, 1'b0, 3, 1'b0, 1'b0);
        // in_valid toggling during feed.
        run_job(0, 1'b1, -1, 1'b0, 1'b0);
        // start held high through FEED and FLUSH.
        run_job(N, 1'b0, -1, 1'b1, 1'b0);

        // Reset while outputs are draining in FLUSH.
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        do_feed(0, 1'b0);
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_job(0, 1'b0, -1, 1'b0, 1'b1);

        // Back-to-back jobs: second start on the cycle after done.
        run_job(0, 1'b0, -1, 1'b0, 1'b0);
        run_job(N, 1'b0, -1, 1'b0, 1'b1);

        repeat (5) tick();
        chk("no_extra_done", n_done, 32'd1);
        chk("idle_out_valid", {31'd0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/systolic_sequencer.md
SYSTOLIC_SEQUENCER -- requirements
Module: systolic_sequencer

Interface
REQ-001 Parameter N, default 8: array dimension (rows = columns = pipeline depth); legal range 2..16.
REQ-002 clk  input  1  the single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low; all state clears while low.
REQ-004 start  input  1  begin one job; sampled only in IDLE.
REQ-005 busy  output  1  high in every state except IDLE.
REQ-006 done  output  1  one-cycle pulse marking job completion.
REQ-007 in_valid / in_ready  input / output  1 / 1  handshake for input row vectors.
REQ-008 in_data  input  N  input row vector; bit j feeds array column j.
REQ-009 out_valid / out_ready  output / input  1 / 1  handshake for output vectors.
REQ-010 out_data  output  N  deskewed output vector.
REQ-011 arr_step  output  1  clock enable for the external N-deep 1-bit systolic array; the array advances one stage per cycle with arr_step high.
REQ-012 arr_din  output  N  skewed column inputs to array row 0.
REQ-013 arr_dout  input  N  column outputs from array row N-1; registered inside the array.

Function
REQ-014 States: IDLE, FEED, FLUSH, DONE; reset state IDLE.
REQ-015 IDLE -> FEED on start=1; start in any other state is ignored.
REQ-016 Step: arr_step=1 and every internal pipeline register advances; stall = out_valid & ~out_ready.
REQ-017 FEED: in_ready = ~stall; step iff in_valid & in_ready; beat counter counts 0..N-1; after N-th accepted beat -> FLUSH.
REQ-018 FLUSH: in_ready=0; step iff ~stall, with zero injected at column inputs; flush counter counts 2N-1 steps.
REQ-019 FLUSH -> DONE when 2N-1 flush steps have completed and all N output vectors have been handshaken; DONE asserts done for one cycle, then -> IDLE.
REQ-020 Skew: column j is delayed by j steps ahead of arr_din; deskew: arr_dout column j is delayed by N-1-j steps; out_data register is the final stage for every column.
REQ-021 Latency: a vector accepted on step edge t is captured into out_data on the (2N-1)-th step edge after t; without stalls, out_valid rises 2N-1 cycles after the acceptance edge.
REQ-022 Validity tracked by a token shift register advancing with each step; out_valid set on a step whose exiting token is 1.
REQ-023 out_valid & out_ready with no new capture in the same cycle clears out_valid; simultaneous handshake and new capture keeps out_valid=1 with new out_data.
REQ-024 out_data/out_valid hold stable while stalled; in_valid without in_ready is ignored (no step).
REQ-025 Exactly N output vectors per job, in input order.
REQ-026 Gaps in in_valid during FEED stall only the feed; no spurious tokens are generated.

Reset
REQ-027 rst_n low at any time, including mid-job: state IDLE, all counters 0, skew/deskew/token registers 0, busy=0, done=0, in_ready=0, out_valid=0, out_data=0, arr_step=0, arr_din=0.
REQ-028 The first job after reset release behaves identically to any later job.

Structure
REQ-029 Shared package holds the state enum type and the default N constant.
REQ-030 Sub-module skew_line (per-column parameterised delay line with enable) is instantiated for both skew and deskew.

Verification
REQ-031 N=8, continuous in_valid and out_ready, in_data = 8'h01,8'h02,...,8'h80 -> outputs the same sequence in order; first out_valid 15 cycles after the first acceptance edge; done pulse once.
REQ-032 out_ready held low for 20 cycles mid-output -> out_data constant, arr_step=0, no vector lost or duplicated.
REQ-033 in_valid toggling 1,0,1,0 during FEED -> arr_step only on accepted beats; output order and values preserved.
REQ-034 start asserted during FEED and FLUSH -> ignored; exactly 8 outputs, single done.
REQ-035 rst_n pulsed low mid-FLUSH -> all outputs at reset values immediately; new job after release yields correct 8 outputs.
REQ-036 Two back-to-back jobs (start on the cycle after done) -> 16 outputs total, no cross-job contamination (zeros flushed between jobs).
